midi_msg_tx: RTL and testbench



---
 rtl/midi_pkg.sv | 36 +++
 rtl/midi_msg_tx.sv | 155 +++++++++++++++
 tb/tb_midi_msg_tx.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// MIDI transmit encoder shared definitions.
// Kind codes, system reset byte, FSM states and message length helper.
package midi_pkg;

   localparam logic [2:0] KIND_NOTE_OFF  = 3'b000;
   localparam logic [2:0] KIND_NOTE_ON   = 3'b001;
   localparam logic [2:0] KIND_KEYPRESS  = 3'b010;
   localparam logic [2:0] KIND_CHANPRESS = 3'b101;
   localparam logic [2:0] KIND_PITCH     = 3'b110;
   localparam logic [2:0] KIND_SYS       = 3'b111;

   localparam logic [7:0] MIDI_SYS_RESET = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_STATUS,
      ST_D1,
      ST_D2,
      ST_CCMD,
      ST_CB0,
      ST_CB1,
      ST_CB2
   } state_e;

   // Number of bytes a channel/system message occupies on the wire.
   function automatic logic [1:0] msg_len(input logic [2:0] kind);
      logic [1:0] len;
      case (kind)
         KIND_SYS:       len = 2'd1;
         KIND_CHANPRESS: len = 2'd2;
         default:        len = 2'd3;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/midi_msg_tx.sv
// MIDI message encoder: serializes note events and 4-byte
// controller frames into a byte stream for the UART.
module midi_msg_tx
   import midi_pkg::*;
#(
   parameter bit RUNNING_STATUS = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ev_valid,
   output logic        ev_ready,
   input  logic [2:0]  ev_kind,
   input  logic [3:0]  ev_channel,
   input  logic [6:0]  ev_data1,
   input  logic [6:0]  ev_data2,
   input  logic        c_valid,
   output logic        c_ready,
   input  logic [6:0]  c_cmd,
   input  logic [7:0]  c_byte0,
   input  logic [7:0]  c_byte1,
   input  logic [7:0]  c_byte2,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        busy,
   output logic [15:0] msg_count,
   input  logic        msg_count_load,
   input  logic [15:0] msg_count_preset
);

   state_e      state_q;
   logic        tx_valid_q;
   logic [7:0]  tx_data_q;
   logic [15:0] msg_count_q;
   logic [7:0]  last_status_q;
   logic [2:0]  kind_q;
   logic [6:0]  d1_q;
   logic [6:0]  d2_q;
   logic [7:0]  b0_q;
   logic [7:0]  b1_q;
   logic [7:0]  b2_q;

   logic [7:0]  status_d;
   logic        skip_d;
   logic [1:0]  len_d;
   logic        last_d;

   // Status byte and running-status skip decision for the pending event.
   always_comb begin
      status_d = (ev_kind == KIND_SYS) ? MIDI_SYS_RESET
                                       : {1'b1, ev_kind, ev_channel};
      skip_d   = RUNNING_STATUS && (ev_kind != KIND_SYS)
                 && (status_d == last_status_q);
   end

   // Flags the byte currently on tx_data as the last of its message.
   always_comb begin
      len_d  = msg_len(kind_q);
      last_d = 1'b0;
      unique case (state_q)
         ST_STATUS: last_d = (len_d == 2'd1);
         ST_D1:     last_d = (len_d == 2'd2);
         ST_D2:     last_d = 1'b1;
         ST_CB2:    last_d = 1'b1;
         default:   last_d = 1'b0;
      endcase
   end

   // Message FSM with registered byte output and completion counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         tx_valid_q    <= 1'b0;
         tx_data_q     <= 8'h00;
         msg_count_q   <= 16'h0000;
         last_status_q <= 8'h00;
         kind_q        <= KIND_NOTE_OFF;
         d1_q          <= 7'h00;
         d2_q          <= 7'h00;
         b0_q          <= 8'h00;
         b1_q          <= 8'h00;
         b2_q          <= 8'h00;
      end else begin
         if (state_q == ST_IDLE) begin
            if (ev_valid) begin
               kind_q     <= ev_kind;
               d1_q       <= ev_data1;
               d2_q       <= ev_data2;
               tx_valid_q <= 1'b1;
               if (skip_d) begin
                  state_q   <= ST_D1;
                  tx_data_q <= {1'b0, ev_data1};
               end else begin
                  state_q   <= ST_STATUS;
                  tx_data_q <= status_d;
                  last_status_q <= (ev_kind == KIND_SYS) ? 8'h00
                                                         : status_d;
               end
            end else if (c_valid) begin
               b0_q          <= c_byte0;
               b1_q          <= c_byte1;
               b2_q          <= c_byte2;
               state_q       <= ST_CCMD;
               tx_valid_q    <= 1'b1;
               tx_data_q     <= {1'b0, c_cmd};
               last_status_q <= 8'h00;
            end
         end else if (tx_valid_q && tx_ready) begin
            if (last_d) begin
               state_q     <= ST_IDLE;
               tx_valid_q  <= 1'b0;
               msg_count_q <= msg_count_q + 16'd1;
            end else begin
               unique case (state_q)
                  ST_STATUS: begin
                     state_q   <= ST_D1;
                     tx_data_q <= {1'b0, d1_q};
                  end
                  ST_D1: begin
                     state_q   <= ST_D2;
                     tx_data_q <= {1'b0, d2_q};
                  end
                  ST_CCMD: begin
                     state_q   <= ST_CB0;
                     tx_data_q <= b0_q;
                  end
                  ST_CB0: begin
                     state_q   <= ST_CB1;
                     tx_data_q <= b1_q;
                  end
                  ST_CB1: begin
                     state_q   <= ST_CB2;
                     tx_data_q <= b2_q;
                  end
                  default: begin
                     state_q    <= ST_IDLE;
                     tx_valid_q <= 1'b0;
                  end
               endcase
            end
         end
         if (msg_count_load) begin
            msg_count_q <= msg_count_preset;
         end
      end
   end

   assign ev_ready  = (state_q == ST_IDLE) && !rst;
   assign c_ready   = (state_q == ST_IDLE) && !ev_valid && !rst;
   assign tx_valid  = tx_valid_q;
   assign tx_data   = tx_data_q;
   assign busy      = (state_q != ST_IDLE);
   assign msg_count = msg_count_q;

endmodule

// File: tb/tb_midi_msg_tx.sv
// Directed bench for midi_msg_tx: one instance without and one
// with running status, byte streams captured per instance.
module tb_midi_msg_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  ev_valid;
   logic [1:0]  c_valid;
   logic [2:0]  ev_kind;
   logic [3:0]  ev_channel;
   logic [6:0]  ev_data1;
   logic [6:0]  ev_data2;
   logic [6:0]  c_cmd;
   logic [7:0]  c_byte0;
   logic [7:0]  c_byte1;
   logic [7:0]  c_byte2;
   logic        tx_ready_a;
   logic        cnt_load;
   logic [15:0] cnt_preset;

   logic [1:0]  ev_ready;
   logic [1:0]  c_ready;
   logic [1:0]  tx_valid;
   logic [1:0]  busy;
   logic [7:0]  tx_data [2];
   logic [15:0] msg_count [2];

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic [7:0] exp_q[$];
   bit bp = 1'b0;
   int ph = 0;
   logic pend = 1'b0;
   logic [7:0] pdat = 8'h00;

   always #5 clk = ~clk;

   midi_msg_tx #(.RUNNING_STATUS(1'b0)) dut_a (
      .clk(clk), .rst(rst),
      .ev_valid(ev_valid[0]), .ev_ready(ev_ready[0]),
      .ev_kind(ev_kind), .ev_channel(ev_channel),
      .ev_data1(ev_data1), .ev_data2(ev_data2),
      .c_valid(c_valid[0]), .c_ready(c_ready[0]),
      .c_cmd(c_cmd), .c_byte0(c_byte0),
      .c_byte1(c_byte1), .c_byte2(c_byte2),
      .tx_valid(tx_valid[0]), .tx_data(tx_data[0]),
      .tx_ready(tx_ready_a), .busy(busy[0]),
      .msg_count(msg_count[0]),
      .msg_count_load(cnt_load),
      .msg_count_preset(cnt_preset)
   );

   midi_msg_tx #(.RUNNING_STATUS(1'b1)) dut_b (
      .clk(clk), .rst(rst),
      .ev_valid(ev_valid[1]), .ev_ready(ev_ready[1]),
      .ev_kind(ev_kind), .ev_channel(ev_channel),
      .ev_data1(ev_data1), .ev_data2(ev_data2),
      .c_valid(c_valid[1]), .c_ready(c_ready[1]),
      .c_cmd(c_cmd), .c_byte0(c_byte0),
      .c_byte1(c_byte1), .c_byte2(c_byte2),
      .tx_valid(tx_valid[1]), .tx_data(tx_data[1]),
      .tx_ready(1'b1), .busy(busy[1]),
      .msg_count(msg_count[1]),
      .msg_count_load(1'b0),
      .msg_count_preset(16'h0000)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_bytes(input string tag, input logic [7:0] got[$],
                            input logic [7:0] exp[$]);
      check({tag, "_len"}, got.size(), exp.size());
      for (int i = 0; i < exp.size(); i++) begin
         if (i < got.size()) check(tag, {24'h0, got[i]}, {24'h0, exp[i]});
      end
   endtask

   // tx_ready for instance a: high, or 1-of-3 when backpressuring
   initial begin
      tx_ready_a = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bp) begin
            ph = (ph == 2) ? 0 : ph + 1;
            tx_ready_a = (ph == 0);
         end else begin
            tx_ready_a = 1'b1;
         end
      end
   end

   // capture handshaked bytes and check hold-while-stalled on a
   always @(negedge clk) begin
      if (tx_valid[0] && tx_ready_a) qa.push_back(tx_data[0]);
      if (tx_valid[1]) qb.push_back(tx_data[1]);
      if (pend && !rst) begin
         check("hold_valid", {31'h0, tx_valid[0]}, 32'h1);
         check("hold_data", {24'h0, tx_data[0]}, {24'h0, pdat});
      end
      pend = tx_valid[0] && !tx_ready_a && !rst;
      pdat = tx_data[0];
   end

   task automatic send_ev(input int s, input logic [2:0] k,
                          input logic [3:0] ch, input logic [6:0] a,
                          input logic [6:0] b);
      bit acc = 1'b0;
      ev_kind = k;
      ev_channel = ch;
      ev_data1 = a;
      ev_data2 = b;
      ev_valid[s] = 1'b1;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         acc = ev_ready[s];
         @(posedge clk);
         #1;
      end
      ev_valid[s] = 1'b0;
      if (!acc) check("ev_accept_timeout", 32'h0, 32'h1);
   endtask

   task automatic send_c(input int s, input logic [6:0] cmd,
                         input logic [7:0] x0, input logic [7:0] x1,
                         input logic [7:0] x2);
      bit acc = 1'b0;
      c_cmd = cmd;
      c_byte0 = x0;
      c_byte1 = x1;
      c_byte2 = x2;
      c_valid[s] = 1'b1;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         acc = c_ready[s];
         @(posedge clk);
         #1;
      end
      c_valid[s] = 1'b0;
      if (!acc) check("c_accept_timeout", 32'h0, 32'h1);
   endtask

   task automatic wait_idle(input int s);
      bit done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         done = !busy[s];
      end
      if (!done) check("idle_timeout", 32'h0, 32'h1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      ev_valid = 2'b00;
      c_valid = 2'b00;
      ev_kind = 3'b000;
      ev_channel = 4'h0;
      ev_data1 = 7'h00;
      ev_data2 = 7'h00;
      c_cmd = 7'h00;
      c_byte0 = 8'h00;
      c_byte1 = 8'h00;
      c_byte2 = 8'h00;
      cnt_load = 1'b0;
      cnt_preset = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_valid", {31'h0, tx_valid[0]}, 32'h0);
      check("rst_tx_data", {24'h0, tx_data[0]}, 32'h0);
      check("rst_count", {16'h0, msg_count[0]}, 32'h0);
      check("rst_busy", {31'h0, busy[0]}, 32'h0);
      check("rst_ev_ready", {31'h0, ev_ready[0]}, 32'h0);
      check("rst_c_ready", {31'h0, c_ready[0]}, 32'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("idle_ev_ready", {31'h0, ev_ready[0]}, 32'h1);
      check("idle_c_ready", {31'h0, c_ready[0]}, 32'h1);

      // note on, byte-per-cycle timing
      qa.delete();
      send_ev(0, 3'b001, 4'd3, 7'h3C, 7'h64);
      check("non_b0_valid", {31'h0, tx_valid[0]}, 32'h1);
      check("non_b0", {24'h0, tx_data[0]}, 32'h93);
      @(posedge clk);
      #1;
      check("non_b1", {24'h0, tx_data[0]}, 32'h3C);
      @(posedge clk);
      #1;
      check("non_b2", {24'h0, tx_data[0]}, 32'h64);
      @(posedge clk);
      #1;
      check("non_done_valid", {31'h0, tx_valid[0]}, 32'h0);
      check("non_done_ready", {31'h0, ev_ready[0]}, 32'h1);
      check("non_count", {16'h0, msg_count[0]}, 32'h1);

      // channel pressure drops data2
      qa.delete();
      send_ev(0, 3'b101, 4'd0, 7'h40, 7'h7F);
      wait_idle(0);
      exp_q = '{8'hD0, 8'h40};
      chk_bytes("chanpress", qa, exp_q);

      // system reset ignores channel
      qa.delete();
      send_ev(0, 3'b111, 4'd5, 7'h11, 7'h22);
      wait_idle(0);
      exp_q = '{8'hFF};
      chk_bytes("sysreset", qa, exp_q);
      check("sys_count", {16'h0, msg_count[0]}, 32'h3);

      // controller frame, tx_ready 1-of-3
      qa.delete();
      bp = 1'b1;
      send_c(0, 7'h12, 8'hA5, 8'h00, 8'hFF);
      wait_idle(0);
      bp = 1'b0;
      exp_q = '{8'h12, 8'hA5, 8'h00, 8'hFF};
      chk_bytes("ctrl_bp", qa, exp_q);
      check("ctrl_count", {16'h0, msg_count[0]}, 32'h4);

      // simultaneous requests: event first, frame waits
      qa.delete();
      ev_kind = 3'b000;
      ev_channel = 4'd1;
      ev_data1 = 7'h40;
      ev_data2 = 7'h00;
      c_cmd = 7'h7F;
      ev_valid[0] = 1'b1;
      c_valid[0] = 1'b1;
      @(negedge clk);
      check("prio_ev_ready", {31'h0, ev_ready[0]}, 32'h1);
      check("prio_c_ready", {31'h0, c_ready[0]}, 32'h0);
      @(posedge clk);
      #1;
      ev_valid[0] = 1'b0;
      @(negedge clk);
      check("prio_c_wait", {31'h0, c_ready[0]}, 32'h0);
      send_c(0, 7'h7F, 8'h01, 8'h02, 8'h03);
      wait_idle(0);
      exp_q = '{8'h81, 8'h40, 8'h00, 8'h7F, 8'h01, 8'h02, 8'h03};
      chk_bytes("prio", qa, exp_q);
      check("prio_count", {16'h0, msg_count[0]}, 32'h6);

      // reset after first byte: aborted, count back to reset value
      send_ev(0, 3'b001, 4'd2, 7'h10, 7'h20);
      check("abort_b0", {24'h0, tx_data[0]}, 32'h92);
      @(posedge clk);
      #1;
      check("abort_b1", {24'h0, tx_data[0]}, 32'h10);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("abort_valid", {31'h0, tx_valid[0]}, 32'h0);
      check("abort_busy", {31'h0, busy[0]}, 32'h0);
      check("abort_count", {16'h0, msg_count[0]}, 32'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      qa.delete();
      send_ev(0, 3'b110, 4'd2, 7'h01, 7'h02);
      wait_idle(0);
      exp_q = '{8'hE2, 8'h01, 8'h02};
      chk_bytes("post_abort", qa, exp_q);
      check("post_abort_count", {16'h0, msg_count[0]}, 32'h1);

      // counter wrap via preset
      cnt_preset = 16'hFFFF;
      cnt_load = 1'b1;
      @(posedge clk);
      #1;
      cnt_load = 1'b0;
      check("preset", {16'h0, msg_count[0]}, 32'hFFFF);
      send_ev(0, 3'b111, 4'd0, 7'h00, 7'h00);
      wait_idle(0);
      check("wrap", {16'h0, msg_count[0]}, 32'h0);

      // running status instance
      qb.delete();
      send_ev(1, 3'b001, 4'd0, 7'h3C, 7'h64);
      wait_idle(1);
      send_ev(1, 3'b001, 4'd0, 7'h3E, 7'h64);
      wait_idle(1);
      exp_q = '{8'h90, 8'h3C, 8'h64, 8'h3E, 8'h64};
      chk_bytes("rs_pair", qb, exp_q);
      qb.delete();
      send_c(1, 7'h01, 8'h00, 8'h00, 8'h00);
      wait_idle(1);
      send_ev(1, 3'b001, 4'd0, 7'h3E, 7'h64);
      wait_idle(1);
      exp_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h90, 8'h3E, 8'h64};
      chk_bytes("rs_ctrl", qb, exp_q);
      check("rs_count", {16'h0, msg_count[1]}, 32'h4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
